// File: rtl/ame_pkg.sv
// Shared types for the numeric dispatch block: operand quad layout, operand
// indices and the dispatcher FSM state encoding.
package ame_pkg;

  localparam int unsigned COMP_DATA_BITS_DEF = 64;

  // Operand positions inside a quad.
  localparam int unsigned M = 3;
  localparam int unsigned D = 2;
  localparam int unsigned L = 1;
  localparam int unsigned C = 0;

  typedef logic [3:0][COMP_DATA_BITS_DEF-1:0] comp_quad_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/ame_num_fifo.sv
// Synchronous first-word-fall-through FIFO holding compute results.
// DEPTH must be a power of two so the pointers wrap naturally.
module ame_num_fifo #(
  parameter int unsigned DW    = 64,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  output logic [DW-1:0] rd_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          wr_ok, rd_ok;

  assign full_o    = (count_q == DEPTH_C);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  assign wr_ok = wr_en_i && !full_o;
  assign rd_ok = rd_en_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_ok);
    rd_ptr_d = rd_ptr_q + AW'(rd_ok);
    count_d  = count_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible until count_q says so.
  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/ame_num_dispatch.sv
// Credit-based dispatcher: issues operand quads to ame_num_compute and returns
// results in order through a FWFT FIFO. AME_NUM_DISPATCH_ERR_EN adds sticky
// {spurious_done, overflow} error flags; otherwise err_o is tied to zero.
//
// state    | meaning
// ST_IDLE  | nothing in flight, no unread result (cnt == 0)
// ST_ISSUE | comp_init_o high, a quad is being handed to compute
// ST_WAIT  | results outstanding or unread, nothing issued this cycle
module ame_num_dispatch
  import ame_pkg::*;
#(
  parameter int unsigned COMP_DATA_BITS = 64,
  parameter int unsigned RES_DEPTH      = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [3:0][COMP_DATA_BITS-1:0] in_data_i,
  output logic                           comp_init_o,
  output logic [3:0][COMP_DATA_BITS-1:0] comp_data_o,
  input  logic                           comp_done_i,
  input  logic [COMP_DATA_BITS-1:0]      comp_data_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [COMP_DATA_BITS-1:0]      out_data_o,
  output logic                           busy_o,
  output logic [1:0]                     err_o
);

  localparam int unsigned CW      = $clog2(RES_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RES_DEPTH);

  state_e                          state_q, state_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic [3:0][COMP_DATA_BITS-1:0]  comp_data_q, comp_data_d;
  logic [CW-1:0]                   fifo_count;
  logic [CW-1:0]                   inflight;
  logic                            fifo_full, fifo_empty;
  logic                            accept, pop, done_ok;

  assign in_ready_o  = (cnt_q < DEPTH_C);
  assign accept      = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  assign out_valid_o = !fifo_empty;
  assign comp_init_o = (state_q == ST_ISSUE);
  assign comp_data_o = comp_data_q;
  assign busy_o      = (state_q != ST_IDLE);

  // Credits not yet in the FIFO are still at the compute unit.
  assign inflight = cnt_q - fifo_count;
  assign done_ok  = comp_done_i && (inflight != '0) && !fifo_full;

  always_comb begin
    cnt_d       = cnt_q + CW'(accept) - CW'(pop);
    comp_data_d = accept ? in_data_i : comp_data_q;
    state_d     = state_q;
    if (accept)            state_d = ST_ISSUE;
    else if (cnt_d == '0)  state_d = ST_IDLE;
    else                   state_d = ST_WAIT;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      comp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      comp_data_q <= comp_data_d;
    end
  end

  ame_num_fifo #(
    .DW    (COMP_DATA_BITS),
    .DEPTH (RES_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .wr_en_i   (done_ok),
    .wr_data_i (comp_data_i),
    .rd_en_i   (pop),
    .rd_data_o (out_data_o),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

`ifdef AME_NUM_DISPATCH_ERR_EN
  logic [1:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (comp_done_i && (inflight == '0)) err_d[1] = 1'b1;
    if (comp_done_i && fifo_full)        err_d[0] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) err_q <= '0;
    else          err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign err_o = 2'b00;
`endif

endmodule

// File: tb/tb_ame_num_dispatch.sv
// Directed bench for ame_num_dispatch with a latency-programmable compute model
// and an in-order result scoreboard.
module tb_ame_num_dispatch;
  import ame_pkg::*;

`ifdef AME_NUM_DISPATCH_ERR_EN
  localparam logic [1:0] ERR_SPUR = 2'b10;
`else
  localparam logic [1:0] ERR_SPUR = 2'b00;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        in_valid_i;
  logic        in_ready_o;
  comp_quad_t  in_data_i;
  logic        comp_init_o;
  comp_quad_t  comp_data_o;
  logic        comp_done_i = 1'b0;
  logic [63:0] comp_data_i = '0;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [63:0] out_data_o;
  logic        busy_o;
  logic [1:0]  err_o;

  int n_chk  = 0;
  int n_fail = 0;

  int          lat      = 3;
  logic        fixed_en = 1'b1;
  logic        spur_req = 1'b0;
  int          cyc      = 0;
  int          due_q[$];
  logic [63:0] val_q[$];
  logic [63:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  ame_num_dispatch #(.COMP_DATA_BITS(64), .RES_DEPTH(8)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .comp_init_o (comp_init_o),
    .comp_data_o (comp_data_o),
    .comp_done_i (comp_done_i),
    .comp_data_i (comp_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  function automatic logic [63:0] model_f(input comp_quad_t q);
    return q[M] * q[D] + (q[L] ^ q[C]);
  endfunction

  // Compute model: returns each issued quad's result lat cycles later.
  always @(negedge clk_i) begin
    cyc = cyc + 1;
    if (comp_init_o) begin
      due_q.push_back(cyc + lat);
      val_q.push_back(fixed_en ? 64'h1234 : model_f(comp_data_o));
    end
    comp_done_i = 1'b0;
    comp_data_i = '0;
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      void'(due_q.pop_front());
      comp_data_i = val_q.pop_front();
      comp_done_i = 1'b1;
    end else if (spur_req) begin
      comp_done_i = 1'b1;
      comp_data_i = 64'hDEAD;
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: apply inputs, score accept/pop, then check issue behaviour.
  task automatic cycle(input logic iv, input comp_quad_t d, input logic ordy);
    logic acc;
    in_valid_i  = iv;
    in_data_i   = d;
    out_ready_i = ordy;
    acc = iv && in_ready_o;
    if (acc) exp_q.push_back(fixed_en ? 64'h1234 : model_f(d));
    if (out_valid_o && ordy) begin
      if (exp_q.size() == 0) chk("pop_unexpected", 1'b1, 1'b0);
      else chk("out_data", out_data_o, exp_q.pop_front());
    end
    @(posedge clk_i);
    #1;
    if (acc) begin
      chk("comp_init", comp_init_o, 1'b1);
      chk("comp_data", comp_data_o, d);
    end else begin
      chk("comp_init_idle", comp_init_o, 1'b0);
    end
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((busy_o || exp_q.size() > 0) && n < bound) begin
      cycle(1'b0, '0, 1'b1);
      n++;
    end
    chk("drain_busy", busy_o, 1'b0);
    chk("drain_left", exp_q.size(), 0);
  endtask

  function automatic comp_quad_t rnd_quad();
    comp_quad_t q;
    for (int k = 0; k < 4; k++) q[k] = {$urandom(), $urandom()};
    return q;
  endfunction

  typedef struct {
    logic        iv;
    logic        ordy;
    logic        exp_rdy;
    logic        exp_ov;
    logic        exp_busy;
    logic [63:0] exp_od;
  } vec_t;

  vec_t       tv[6];
  comp_quad_t q0;
  int         acc_n;
  int         n;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tv[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0};
    tv[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0};
    tv[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0};
    tv[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0};
    tv[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h1234};
    tv[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0};

    rst_n_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_n_i = 1'b1;

    chk("rst_in_ready", in_ready_o, 1'b1);
    chk("rst_init", comp_init_o, 1'b0);
    chk("rst_comp_data", comp_data_o, '0);
    chk("rst_out_valid", out_valid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_err", err_o, 2'b00);

    // Single quad, latency 3, fixed result 0x1234.
    lat = 3; fixed_en = 1'b1;
    q0 = {64'd5, 64'd4, 64'd3, 64'd2};
    for (int i = 0; i < 6; i++) begin
      cycle(tv[i].iv, q0, tv[i].ordy);
      chk("vec_in_ready", in_ready_o, tv[i].exp_rdy);
      chk("vec_out_valid", out_valid_o, tv[i].exp_ov);
      chk("vec_busy", busy_o, tv[i].exp_busy);
      if (tv[i].exp_ov) chk("vec_out_data", out_data_o, tv[i].exp_od);
    end

    // Back-to-back stream, latency 4.
    lat = 4; fixed_en = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (!in_ready_o) chk("b2b_in_ready", in_ready_o, 1'b1);
      cycle(1'b1, rnd_quad(), 1'b1);
    end
    drain(100);
    chk("b2b_err", err_o, 2'b00);

    // Backpressure: only RES_DEPTH credits available.
    lat = 1;
    acc_n = 0;
    for (int i = 0; i < 10; i++) begin
      if (in_ready_o) acc_n++;
      cycle(1'b1, rnd_quad(), 1'b0);
    end
    chk("bp_accepted", acc_n, 8);
    chk("bp_in_ready_full", in_ready_o, 1'b0);
    chk("bp_out_valid", out_valid_o, 1'b1);
    cycle(1'b1, rnd_quad(), 1'b1);
    chk("bp_ready_after_pop", in_ready_o, 1'b1);
    cycle(1'b1, rnd_quad(), 1'b1);
    chk("bp_cnt7_hold", in_ready_o, 1'b1);
    cycle(1'b1, rnd_quad(), 1'b0);
    chk("bp_cnt8_again", in_ready_o, 1'b0);
    drain(100);

    // Spurious done while idle.
    spur_req = 1'b1;
    cycle(1'b0, '0, 1'b0);
    spur_req = 1'b0;
    cycle(1'b0, '0, 1'b0);
    chk("spur_err", err_o, ERR_SPUR);
    chk("spur_out_valid", out_valid_o, 1'b0);
    chk("spur_busy", busy_o, 1'b0);
    cycle(1'b0, '0, 1'b0);
    chk("spur_sticky", err_o, ERR_SPUR);

    // Reset with three quads in flight; late dones must be discarded.
    lat = 20;
    for (int i = 0; i < 3; i++) cycle(1'b1, rnd_quad(), 1'b0);
    in_valid_i = 1'b0;
    rst_n_i = 1'b0;
    #1;
    chk("mid_rst_init", comp_init_o, 1'b0);
    chk("mid_rst_comp_data", comp_data_o, '0);
    chk("mid_rst_out_valid", out_valid_o, 1'b0);
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_err", err_o, 2'b00);
    exp_q.delete();
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    chk("rel_in_ready", in_ready_o, 1'b1);
    n = 0;
    while (due_q.size() > 0 && n < 60) begin
      cycle(1'b0, '0, 1'b1);
      n++;
    end
    chk("late_done_timeout", due_q.size(), 0);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    chk("late_out_valid", out_valid_o, 1'b0);
    chk("late_busy", busy_o, 1'b0);
    chk("late_err", err_o, ERR_SPUR);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
